pio_poll_master: RTL and testbench
==================================

// Module: pio_poll_master
// PURPOSE
//  Avalon-MM master that periodically polls a 1-bit PIO input slave (register 0, bit 0).
//  Debounces the sampled value and reports each stable level change as an event.
//  The event is presented on a valid/ack handshake to the robot-control logic.
//  Sits between the input-PIO slave and game logic, so no CPU polling loop is needed.
// PARAMETERS
//  POLL_DIV      50000  clock cycles between poll ticks (>=2)
//  READ_LATENCY  1      slave read latency in cycles after the read is accepted (>=1)
//  DEBOUNCE      3      consecutive differing samples needed to change level (>=1)
//  CNT_W         16     width of the tick counter (must hold POLL_DIV-1)
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   reset; asynchronous, active-low
//  enable          in   1   1 = polling runs; 0 = tick counter held at 0
//  avm_address     out  2   always 0 (data register)
//  avm_read        out  1   read request
//  avm_waitrequest in   1   slave stall; the read is accepted on an edge where it is 0
//  avm_readdata    in   32  slave data; only bit 0 is used, [31:1] ignored
//  level           out  1   debounced stable level
//  event_valid     out  1   level-change event pending
//  event_level     out  1   new level carried by the pending event
//  event_ack       in   1   consumer accepts the event
//  event_overflow  out  1   sticky: a new event overwrote an unacked one
//  missed_tick     out  1   1-cycle pulse: tick arrived while a poll was in progress
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0, level=0, state IDLE, all counters 0.
//  Tick counter: increments while enable=1 and wraps at POLL_DIV-1; tick = (count==POLL_DIV-1).
//  FSM
//    IDLE: on tick -> REQ.
//    REQ: avm_read=1, avm_address=0 and held stable while avm_waitrequest=1.
//      On an edge with waitrequest=0 -> WAIT; latency counter loads READ_LATENCY.
//    WAIT: avm_read=0; counter decrements each cycle.
//      avm_readdata[0] is captured on the READ_LATENCY-th edge after acceptance -> EVAL.
//    EVAL: one cycle, then -> IDLE.
//  Tick while state != IDLE: the tick is dropped and missed_tick pulses for that cycle.
//  Poll period: a poll starts every POLL_DIV cycles; it never starts earlier.
//  Debounce (in EVAL):
//    sample != level: match count +1. When the count reaches DEBOUNCE:
//      level <= sample, count <= 0, and an event is raised.
//    sample == level: count <= 0.
//  Event handshake:
//    event_valid stays 1 until an edge with event_ack=1; event_level stays stable meanwhile.
//    New event while event_valid=1 and ack=0: event_level <= newest level, event_overflow <= 1.
//    event_ack=1 clears event_valid and event_overflow.
//    Same-cycle new event and ack: the new event wins. event_valid stays 1, overflow cleared.
//  enable=0 mid-poll: the outstanding read finishes (REQ is never abandoned) and the result is evaluated.
//    The FSM then stays in IDLE; level and count are kept.
//  Reset mid-read: avm_read drops immediately (async). Any stale slave data is never captured.
// TESTING (POLL_DIV=4, READ_LATENCY=1, DEBOUNCE=2 unless stated)
//  1 Reset: assert reset_n=0 mid-run -> avm_read, level, event_valid, event_overflow, missed_tick all 0 same cycle.
//  2 Polling: enable=1, waitrequest=0 -> avm_read high exactly 1 cycle every 4 cycles, avm_address=0.
//  3 Stall: waitrequest=1 for 3 cycles -> avm_read held 4 cycles, address stable; missed_tick pulses once.
//  4 Debounce: readdata=1 on 2 polls -> level=1, event_valid=1, event_level=1.
//    readdata=0 for a single poll then 1 -> no event.
//  5 Overflow: 1 then 0 transitions without ack -> event_overflow=1, event_level=0.
//    event_ack=1 -> valid=0, overflow=0 next edge.
//  6 Enable drop in REQ with waitrequest=1: the read stays asserted until accepted,
//    the sample is captured, then there are no further reads.

Source files
------------

// File: rtl/pio_poll_master.sv
// Avalon-MM master that polls bit 0 of a PIO slave every POLL_DIV cycles,
// debounces the sample and reports stable level changes on a valid/ack handshake.
module pio_poll_master #(
    parameter int unsigned POLL_DIV     = 50000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DEBOUNCE     = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        level,
    output logic        event_valid,
    output logic        event_level,
    input  logic        event_ack,
    output logic        event_overflow,
    output logic        missed_tick
);

    localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StEval} state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DB_W-1:0]   match_cnt;
    logic              sample_bit;
    logic              tick;
    logic              new_event;
    logic              unused_readdata;

    assign avm_address     = 2'b00;
    assign unused_readdata = ^avm_readdata[31:1];

    assign tick        = (tick_cnt == CNT_W'(POLL_DIV - 1));
    assign missed_tick = tick && (state != StIdle);

    // A level change is committed only on the DEBOUNCE-th consecutive differing sample.
    assign new_event = (state == StEval) && (sample_bit != level) &&
                       (match_cnt == DB_W'(DEBOUNCE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= StIdle;
            avm_read       <= 1'b0;
            lat_cnt        <= '0;
            match_cnt      <= '0;
            sample_bit     <= 1'b0;
            level          <= 1'b0;
            event_valid    <= 1'b0;
            event_level    <= 1'b0;
            event_overflow <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (tick) begin
                        state    <= StReq;
                        avm_read <= 1'b1;
                    end
                end
                StReq: begin
                    if (!avm_waitrequest) begin
                        state    <= StWait;
                        avm_read <= 1'b0;
                        lat_cnt  <= LAT_W'(READ_LATENCY);
                    end
                end
                StWait: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (lat_cnt == LAT_W'(1)) begin
                        sample_bit <= avm_readdata[0];
                        state      <= StEval;
                    end
                end
                StEval: begin
                    state <= StIdle;
                    if (sample_bit != level) begin
                        if (new_event) begin
                            level     <= sample_bit;
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + DB_W'(1);
                        end
                    end else begin
                        match_cnt <= '0;
                    end
                end
                default: state <= StIdle;
            endcase

            // A new event beats a same-cycle ack; overflow only if the old one was never taken.
            if (new_event) begin
                event_valid    <= 1'b1;
                event_level    <= sample_bit;
                event_overflow <= event_valid && !event_ack;
            end else if (event_ack) begin
                event_valid    <= 1'b0;
                event_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_poll_master.sv
// Randomized and directed stimulus for pio_poll_master, checked every cycle against a
// timestamp-based reference model of the polling, debounce and event rules.
module tb_pio_poll_master;

    localparam int PD = 4;
    localparam int RL = 1;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        event_ack = 1'b0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        level;
    logic        event_valid;
    logic        event_level;
    logic        event_overflow;
    logic        missed_tick;

    pio_poll_master #(
        .POLL_DIV     (PD),
        .READ_LATENCY (RL),
        .DEBOUNCE     (DB),
        .CNT_W        (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .level           (level),
        .event_valid     (event_valid),
        .event_level     (event_level),
        .event_ack       (event_ack),
        .event_overflow  (event_overflow),
        .missed_tick     (missed_tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: cycle index, tick phase, poll start/accept timestamps, debounce state.
    int   m_cyc;
    int   m_ph;
    int   m_acc;
    int   m_mcount;
    logic m_busy;
    logic m_sample;
    logic m_level;
    logic m_ev_valid;
    logic m_ev_level;
    logic m_ev_ovf;
    logic drv_bit = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_cyc      = 0;
        m_ph       = 0;
        m_acc      = -1;
        m_mcount   = 0;
        m_busy     = 1'b0;
        m_sample   = 1'b0;
        m_level    = 1'b0;
        m_ev_valid = 1'b0;
        m_ev_level = 1'b0;
        m_ev_ovf   = 1'b0;
    endtask

    // One clock cycle: compare outputs, drive inputs, advance the model across the edge.
    task automatic step(input logic en, input logic wr, input logic [31:0] rd, input logic ack);
        logic busy_before;
        logic tick;
        logic new_ev;
        @(negedge clk);
        check_eq("avm_read", avm_read, m_busy && (m_acc < 0));
        check_eq("avm_address", avm_address, 0);
        check_eq("level", level, m_level);
        check_eq("event_valid", event_valid, m_ev_valid);
        check_eq("event_level", event_level, m_ev_level);
        check_eq("event_overflow", event_overflow, m_ev_ovf);
        check_eq("missed_tick", missed_tick, (m_ph == PD - 1) && m_busy);
        enable          = en;
        avm_waitrequest = wr;
        avm_readdata    = rd;
        event_ack       = ack;

        busy_before = m_busy;
        tick        = (m_ph == PD - 1);
        new_ev      = 1'b0;
        if (m_busy) begin
            if (m_acc < 0) begin
                if (!wr) m_acc = m_cyc;
            end else if (m_cyc == m_acc + RL) begin
                m_sample = rd[0];
            end else if (m_cyc == m_acc + RL + 1) begin
                if (m_sample != m_level) begin
                    m_mcount++;
                    if (m_mcount == DB) begin
                        m_level  = m_sample;
                        m_mcount = 0;
                        new_ev   = 1'b1;
                    end
                end else begin
                    m_mcount = 0;
                end
                m_busy = 1'b0;
                m_acc  = -1;
            end
        end
        if (new_ev) begin
            m_ev_ovf   = m_ev_valid && !ack;
            m_ev_valid = 1'b1;
            m_ev_level = m_level;
        end else if (ack) begin
            m_ev_valid = 1'b0;
            m_ev_ovf   = 1'b0;
        end
        if (tick && !busy_before) m_busy = 1'b1;
        m_ph = en ? ((m_ph == PD - 1) ? 0 : m_ph + 1) : 0;
        m_cyc++;
    endtask

    task automatic dstep(input logic en, input logic wr, input logic b, input logic ack);
        logic [31:0] rd;
        rd    = $urandom();
        rd[0] = b;
        step(en, wr, rd, ack);
    endtask

    task automatic rnd_step(input int p_wait, input int p_ack, input int p_en, input int p_flip);
        logic [31:0] rd;
        if ($urandom_range(99) < p_flip) drv_bit = ~drv_bit;
        rd    = $urandom();
        rd[0] = drv_bit;
        step($urandom_range(99) < p_en, $urandom_range(99) < p_wait, rd,
             $urandom_range(99) < p_ack);
    endtask

    // Step until the model says the next cycle carries a fresh read request.
    task automatic find_req(input logic en);
        int k;
        k = 0;
        while (!(m_busy && (m_acc < 0)) && k < 16) begin
            dstep(en, 1'b1, drv_bit, 1'b0);
            k++;
        end
        check_eq("find_req", m_busy && (m_acc < 0), 1);
    endtask

    task automatic reset_mid_read();
        @(posedge clk);
        #2;
        check_eq("pre_rst_read", avm_read, 1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_avm_read", avm_read, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_event_valid", event_valid, 0);
        check_eq("rst_event_level", event_level, 0);
        check_eq("rst_event_overflow", event_overflow, 0);
        check_eq("rst_missed_tick", missed_tick, 0);
        model_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;

        repeat (12) dstep(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8)  dstep(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (4)  dstep(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8)  dstep(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8)  dstep(1'b1, 1'b0, 1'b0, 1'b0);
        dstep(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3)  dstep(1'b1, 1'b0, 1'b0, 1'b0);

        find_req(1'b1);
        repeat (3)  dstep(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) dstep(1'b1, 1'b0, 1'b0, 1'b0);

        repeat (300) rnd_step(30, 15, 97, 35);

        find_req(1'b1);
        reset_mid_read();

        repeat (200) rnd_step(25, 20, 95, 40);

        drv_bit = 1'b1;
        find_req(1'b1);
        repeat (3)  dstep(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (20) dstep(1'b0, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
